reaction_timer_ctrl: RTL and testbench



---
 rtl/reaction_timer_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_reaction_timer_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_ctrl.sv
// Reaction-game controller: random start delay, millisecond BCD reaction timer,
// cheat/timeout detection and a best-time register.
module reaction_timer_ctrl #(
    parameter int TICKS_PER_MS  = 100000,
    parameter int RAND_W        = 4,
    parameter int DELAY_UNIT_MS = 1000,
    parameter int MIN_DELAY     = 2,
    parameter int TIMEOUT_MS    = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_btn,
    input  logic              stop_btn,
    input  logic              clear_btn,
    input  logic [RAND_W-1:0] rand_val,
    output logic              ltr_flag,
    output logic              led0,
    output logic [3:0]        digit0,
    output logic [3:0]        digit1,
    output logic [3:0]        digit2,
    output logic [3:0]        digit3,
    output logic [13:0]       best_ms,
    output logic              best_valid
);

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [13:0] bcd_to_bin(input logic [15:0] v);
        return 14'(v[15:12]) * 14'd1000 + 14'(v[11:8]) * 14'd100
             + 14'(v[7:4]) * 14'd10 + 14'(v[3:0]);
    endfunction

    localparam int                  PRESC_W      = $clog2(TICKS_PER_MS);
    localparam int                  DLY_W        = $clog2(((2 ** RAND_W) - 1) * DELAY_UNIT_MS + 1);
    localparam logic [PRESC_W-1:0]  TICK_LAST    = PRESC_W'(TICKS_PER_MS - 1);
    localparam logic [13:0]         TIMEOUT_LAST = 14'(TIMEOUT_MS - 1);
    localparam logic [15:0]         TIMEOUT_BCD  = to_bcd(TIMEOUT_MS);
    localparam logic [31:0]         MIN_UNITS    = 32'(MIN_DELAY);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WAIT    = 3'd2,
        S_RUN     = 3'd3,
        S_DONE    = 3'd4,
        S_CHEAT   = 3'd5,
        S_TIMEOUT = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic                start_prev_q, stop_prev_q, clear_prev_q;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [DLY_W-1:0]    delay_q, delay_d;
    logic [15:0]         bcd_q, bcd_d;
    logic [13:0]         best_ms_q, best_ms_d;
    logic                best_valid_q, best_valid_d;
    logic                done_entry_q, done_entry_d;

    logic                start_e, stop_e, clear_e;
    logic                ms_tick;
    logic [13:0]         count_bin;
    logic [31:0]         rand_ext, units;
    logic [15:0]         disp;

    always_comb begin
        start_e   = start_btn & ~start_prev_q;
        stop_e    = stop_btn & ~stop_prev_q;
        clear_e   = clear_btn & ~clear_prev_q;
        ms_tick   = (presc_q == TICK_LAST);
        count_bin = bcd_to_bin(bcd_q);
        rand_ext  = 32'(rand_val);
        units     = (rand_ext < MIN_UNITS) ? MIN_UNITS : rand_ext;
    end

    // Next-state: cheat beats delay expiry, stop beats timeout, clear beats everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_e) state_d = S_LOAD;
            end
            S_LOAD: state_d = S_WAIT;
            S_WAIT: begin
                if (stop_e)              state_d = S_CHEAT;
                else if (delay_q == '0)  state_d = S_RUN;
            end
            S_RUN: begin
                if (stop_e)                                     state_d = S_DONE;
                else if (ms_tick && count_bin == TIMEOUT_LAST)  state_d = S_TIMEOUT;
            end
            S_DONE, S_CHEAT, S_TIMEOUT: begin
                if (start_e) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
        if (clear_e) state_d = S_IDLE;
    end

    always_comb begin
        presc_d = ms_tick ? '0 : presc_q + PRESC_W'(1);
        if ((state_d == S_WAIT && state_q != S_WAIT) || (state_d == S_RUN && state_q != S_RUN)) begin
            presc_d = '0;
        end

        delay_d = delay_q;
        if (state_q == S_LOAD) begin
            delay_d = DLY_W'(units * DELAY_UNIT_MS);
        end else if (state_q == S_WAIT && ms_tick && delay_q != '0) begin
            delay_d = delay_q - DLY_W'(1);
        end

        // The count freezes on the cycle RUN is left, so DONE shows the pre-tick value.
        bcd_d = bcd_q;
        if (state_q == S_LOAD) begin
            bcd_d = '0;
        end else if (state_q == S_RUN && state_d == S_RUN && ms_tick) begin
            bcd_d = bcd_inc(bcd_q);
        end

        done_entry_d = (state_d == S_DONE) && (state_q != S_DONE);

        best_ms_d    = best_ms_q;
        best_valid_d = best_valid_q;
        if (state_q == S_IDLE && clear_e) begin
            best_ms_d    = '0;
            best_valid_d = 1'b0;
        end else if (state_q == S_DONE && done_entry_q && (!best_valid_q || count_bin < best_ms_q)) begin
            best_ms_d    = count_bin;
            best_valid_d = 1'b1;
        end
    end

    always_comb begin
        ltr_flag = 1'b0;
        led0     = 1'b0;
        disp     = 16'hFFFF;
        case (state_q)
            S_IDLE: begin
                ltr_flag = 1'b1;
                disp     = 16'hFF5A;
            end
            S_LOAD, S_WAIT: disp = 16'hFFFF;
            S_RUN: begin
                led0 = 1'b1;
                disp = bcd_q;
            end
            S_DONE:    disp = bcd_q;
            S_CHEAT: begin
                ltr_flag = 1'b1;
                disp     = 16'hEEEE;
            end
            S_TIMEOUT: disp = TIMEOUT_BCD;
            default: begin
                ltr_flag = 1'b1;
                disp     = 16'hFF5A;
            end
        endcase
    end

    assign digit0     = disp[3:0];
    assign digit1     = disp[7:4];
    assign digit2     = disp[11:8];
    assign digit3     = disp[15:12];
    assign best_ms    = best_ms_q;
    assign best_valid = best_valid_q;

    // Button history resets high so a button held through reset produces no edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b1;
            stop_prev_q  <= 1'b1;
            clear_prev_q <= 1'b1;
            presc_q      <= '0;
            delay_q      <= '0;
            bcd_q        <= '0;
            best_ms_q    <= '0;
            best_valid_q <= 1'b0;
            done_entry_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_btn;
            stop_prev_q  <= stop_btn;
            clear_prev_q <= clear_btn;
            presc_q      <= presc_d;
            delay_q      <= delay_d;
            bcd_q        <= bcd_d;
            best_ms_q    <= best_ms_d;
            best_valid_q <= best_valid_d;
            done_entry_q <= done_entry_d;
        end
    end

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Directed bench for reaction_timer_ctrl: table of full game rounds plus
// hand-written sequences for reset, cheat, clear priority and mid-run reset.
module tb_reaction_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_btn = 1'b1;
    logic        stop_btn = 1'b0;
    logic        clear_btn = 1'b0;
    logic [3:0]  rand_val = 4'd0;
    logic        ltr_flag, led0, best_valid;
    logic [3:0]  digit0, digit1, digit2, digit3;
    logic [13:0] best_ms;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  rnd;
        int          stop_cyc;
        int          exp_wait;
        int          exp_run;
        logic [15:0] exp_dig;
        int          exp_best;
    } round_t;

    round_t rounds[6];

    reaction_timer_ctrl #(
        .TICKS_PER_MS (10),
        .RAND_W       (4),
        .DELAY_UNIT_MS(2),
        .MIN_DELAY    (2),
        .TIMEOUT_MS   (50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_btn (start_btn),
        .stop_btn  (stop_btn),
        .clear_btn (clear_btn),
        .rand_val  (rand_val),
        .ltr_flag  (ltr_flag),
        .led0      (led0),
        .digit0    (digit0),
        .digit1    (digit1),
        .digit2    (digit2),
        .digit3    (digit3),
        .best_ms   (best_ms),
        .best_valid(best_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input logic ltr, input logic [15:0] dig, input logic led);
        chk({tag, "_ltr"}, int'(ltr_flag), int'(ltr));
        chk({tag, "_digits"}, int'({digit3, digit2, digit1, digit0}), int'(dig));
        chk({tag, "_led"}, int'(led0), int'(led));
    endtask

    task automatic chk_best(input string tag, input int b, input logic v);
        chk({tag, "_best_ms"}, int'(best_ms), b);
        chk({tag, "_best_valid"}, int'(best_valid), int'(v));
    endtask

    task automatic pulse_start();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_btn = 1'b1;
        tick();
        stop_btn = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_btn = 1'b1;
        tick();
        clear_btn = 1'b0;
    endtask

    // Leaves the bench in the first RUN cycle; returns number of WAIT cycles seen.
    task automatic wait_for_led(output int n);
        n = 0;
        while (!led0 && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic do_round(input round_t r, input string tag);
        int n;
        rand_val = r.rnd;
        pulse_start();
        chk_disp({tag, "_load"}, 1'b0, 16'hFFFF, 1'b0);
        tick();
        wait_for_led(n);
        chk({tag, "_wait_len"}, n, r.exp_wait);
        if (r.stop_cyc >= 0) begin
            repeat (r.stop_cyc) tick();
            chk({tag, "_led_before_stop"}, int'(led0), 1);
            pulse_stop();
        end else begin
            n = 0;
            while (led0 && n < 2000) begin
                tick();
                n++;
            end
            chk({tag, "_run_len"}, n, r.exp_run);
        end
        chk_disp({tag, "_result"}, 1'b0, r.exp_dig, 1'b0);
        tick();
        chk_best(tag, r.exp_best, 1'b1);
    endtask

    initial begin
        int n;
        rounds[0] = '{4'd5,  123, 101, 0,   16'h0012, 12};
        rounds[1] = '{4'd0,  -1,  41,  500, 16'h0050, 12};
        rounds[2] = '{4'd1,  302, 41,  0,   16'h0030, 12};
        rounds[3] = '{4'd3,  79,  61,  0,   16'h0007, 7};
        rounds[4] = '{4'd15, 499, 301, 0,   16'h0049, 7};
        rounds[5] = '{4'd4,  10,  81,  0,   16'h0001, 1};

        // Reset with start held: must stay in IDLE until a fresh press.
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        chk_disp("reset", 1'b1, 16'hFF5A, 1'b0);
        chk_best("reset", 0, 1'b0);
        repeat (3) tick();
        chk_disp("held_start", 1'b1, 16'hFF5A, 1'b0);
        start_btn = 1'b0;
        tick();
        pulse_start();
        chk_disp("repress", 1'b0, 16'hFFFF, 1'b0);
        pulse_clear();
        chk_disp("clear_in_load", 1'b1, 16'hFF5A, 1'b0);

        for (int i = 0; i < 6; i++) begin
            do_round(rounds[i], $sformatf("round%0d", i));
        end

        // Stop during WAIT -> CHEAT, best untouched.
        rand_val = 4'd0;
        pulse_start();
        tick();
        repeat (20) tick();
        pulse_stop();
        chk_disp("cheat", 1'b1, 16'hEEEE, 1'b0);
        tick();
        chk_best("cheat", 1, 1'b1);

        // Stop on the cycle the delay reaches zero -> still CHEAT.
        pulse_start();
        tick();
        repeat (40) tick();
        chk("cheat_zero_still_wait", int'(led0), 0);
        pulse_stop();
        chk_disp("cheat_zero", 1'b1, 16'hEEEE, 1'b0);
        tick();
        chk_disp("cheat_zero_hold", 1'b1, 16'hEEEE, 1'b0);

        // Clear during RUN -> IDLE, best kept.
        pulse_start();
        tick();
        wait_for_led(n);
        chk("clear_run_wait_len", n, 41);
        repeat (25) tick();
        chk("clear_run_live", int'({digit3, digit2, digit1, digit0}), 16'h0002);
        pulse_clear();
        chk_disp("clear_run", 1'b1, 16'hFF5A, 1'b0);
        tick();
        chk_best("clear_run", 1, 1'b1);

        // Clear in IDLE wipes the best time.
        pulse_clear();
        chk_best("clear_idle", 0, 1'b0);

        // Start and clear together from CHEAT -> IDLE.
        pulse_start();
        tick();
        pulse_stop();
        chk_disp("pre_prio_cheat", 1'b1, 16'hEEEE, 1'b0);
        start_btn = 1'b1;
        clear_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        clear_btn = 1'b0;
        chk_disp("start_clear", 1'b1, 16'hFF5A, 1'b0);
        tick();
        chk_disp("start_clear_hold", 1'b1, 16'hFF5A, 1'b0);

        // Reset mid-RUN after a valid result.
        do_round('{4'd2, 55, 41, 0, 16'h0005, 5}, "pre_rst");
        pulse_start();
        tick();
        wait_for_led(n);
        repeat (35) tick();
        chk("rst_run_live", int'({digit3, digit2, digit1, digit0}), 16'h0003);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_disp("rst_run", 1'b1, 16'hFF5A, 1'b0);
        chk_best("rst_run", 0, 1'b0);
        tick();
        do_round('{4'd2, 15, 41, 0, 16'h0001, 1}, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
